// File: rtl/lc3_stim_pkg.sv
// Shared types and entry-layout helpers for the LC-3 stimulus sequencer.
// Script entry layout, MSB first: {op, arg, delay}.
package lc3_stim_pkg;

    typedef enum logic [2:0] {
        NOP        = 3'd0,
        SET_SW     = 3'd1,
        PULSE_RUN  = 3'd2,
        PULSE_CONT = 3'd3,
        WAIT       = 3'd4,
        CHECK      = 3'd5,
        WAIT_EQ    = 3'd6,
        HALT       = 3'd7
    } stim_op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_EXEC,
        ST_PULSE,
        ST_GAP,
        ST_DONE
    } stim_state_e;

    localparam int OP_W = 3;

    function automatic int entry_w(input int data_w, input int delay_w);
        return OP_W + data_w + delay_w;
    endfunction

    function automatic int arg_lsb(input int delay_w);
        return delay_w;
    endfunction

    function automatic int op_lsb(input int data_w, input int delay_w);
        return data_w + delay_w;
    endfunction

endpackage

// File: rtl/lc3_stim_script_ram.sv
// Script storage: one write port and one synchronous read port.
// Contents are not reset; an entry is only read after it has been programmed.
module lc3_stim_script_ram #(
    parameter int  DEPTH = 64,
    parameter int  WIDTH = 31,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_re,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
        if (i_re) r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/lc3_stim_sequencer.sv
// Scripted stimulus engine for the LC-3 top: SW writes, Run/Continue pulses, waits, checks.
// Define STIM_ERR_LOG_EN to capture the step index and observed value of the first failure.
module lc3_stim_sequencer
    import lc3_stim_pkg::*;
#(
    parameter int  SW_W        = 10,
    parameter int  DATA_W      = 16,
    parameter int  DEPTH       = 64,
    parameter int  DELAY_W     = 12,
    parameter int  PULSE_CYC   = 2,
    parameter int  KEY_ACT_LOW = 0,
    localparam int AW          = $clog2(DEPTH),
    localparam int ENTRY_W     = entry_w(DATA_W, DELAY_W)
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_prog_we,
    input  logic [AW-1:0]      i_prog_addr,
    input  logic [ENTRY_W-1:0] i_prog_data,
    input  logic               i_start,
    input  logic               i_abort,
    input  logic [DATA_W-1:0]  i_obs_data,
    output logic [SW_W-1:0]    o_sw,
    output logic               o_run,
    output logic               o_continue,
    output logic               o_busy,
    output logic               o_done,
    output logic [AW-1:0]      o_step_idx,
    output logic [7:0]         o_err_cnt,
    output logic [AW-1:0]      o_err_idx,
    output logic [DATA_W-1:0]  o_err_obs
);

    localparam int   PW       = (PULSE_CYC > 2) ? $clog2(PULSE_CYC) : 1;
    localparam logic KEY_IDLE = (KEY_ACT_LOW != 0);
    localparam int   ARG_LSB  = arg_lsb(DELAY_W);
    localparam int   OP_LSB   = op_lsb(DATA_W, DELAY_W);

    stim_state_e       r_state;
    logic [SW_W-1:0]   r_sw;
    logic              r_run, r_cont, r_busy, r_done;
    logic [AW-1:0]     r_step;
    logic [7:0]        r_err_cnt;
    logic [DELAY_W-1:0] r_cnt;
    logic [PW-1:0]     r_pcnt;

    logic [ENTRY_W-1:0] w_rdata;
    stim_op_e           w_op;
    logic [DATA_W-1:0]  w_arg;
    logic [DELAY_W-1:0] w_delay;
    logic               w_match, w_wait_to, w_fail, w_start_ok;
    logic [DELAY_W:0]   w_cnt_inc;
    logic [DELAY_W-1:0] w_fin_dly, w_fin_cnt;
    stim_state_e        w_fin_state;
    logic [AW-1:0]      w_fin_step;

    lc3_stim_script_ram #(.DEPTH(DEPTH), .WIDTH(ENTRY_W)) u_ram (
        .i_clk   (i_clk),
        .i_we    (i_prog_we && !r_busy),
        .i_waddr (i_prog_addr),
        .i_wdata (i_prog_data),
        .i_re    (r_state == ST_FETCH),
        .i_raddr (r_step),
        .o_rdata (w_rdata)
    );

    assign w_op       = stim_op_e'(w_rdata[OP_LSB +: OP_W]);
    assign w_arg      = w_rdata[ARG_LSB +: DATA_W];
    assign w_delay    = w_rdata[DELAY_W-1:0];
    assign w_match    = (i_obs_data == w_arg);
    assign w_cnt_inc  = {1'b0, r_cnt} + (DELAY_W+1)'(1);
    assign w_wait_to  = (w_cnt_inc >= {1'b0, w_delay});
    assign w_start_ok = i_start && (r_state == ST_IDLE || r_state == ST_DONE);
    assign w_fail     = (r_state == ST_EXEC) && !w_match &&
                        ((w_op == CHECK) || (w_op == WAIT_EQ && w_wait_to));

    // Step completion: zero delay skips GAP so a step costs FETCH+EXEC+pulse+delay.
    always_comb begin
        w_fin_dly   = (r_state == ST_GAP || w_op == WAIT_EQ) ? '0 : w_delay;
        w_fin_state = ST_GAP;
        w_fin_step  = r_step;
        w_fin_cnt   = w_fin_dly - DELAY_W'(1);
        if (w_fin_dly == '0) begin
            w_fin_cnt = '0;
            if (r_step == AW'(DEPTH-1)) begin
                w_fin_state = ST_DONE;
            end else begin
                w_fin_state = ST_FETCH;
                w_fin_step  = r_step + AW'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= ST_IDLE;
            r_sw      <= '0;
            r_run     <= KEY_IDLE;
            r_cont    <= KEY_IDLE;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_step    <= '0;
            r_err_cnt <= '0;
            r_cnt     <= '0;
            r_pcnt    <= '0;
        end else if (i_abort) begin
            r_state <= ST_IDLE;
            r_run   <= KEY_IDLE;
            r_cont  <= KEY_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_start_ok) begin
                        r_state   <= ST_FETCH;
                        r_step    <= '0;
                        r_err_cnt <= '0;
                        r_busy    <= 1'b1;
                        r_done    <= 1'b0;
                    end
                end
                ST_FETCH: begin
                    r_state <= ST_EXEC;
                    r_cnt   <= '0;
                end
                ST_EXEC: begin
                    case (w_op)
                        PULSE_RUN, PULSE_CONT: begin
                            if (w_op == PULSE_RUN) r_run  <= ~KEY_IDLE;
                            else                   r_cont <= ~KEY_IDLE;
                            r_pcnt  <= PW'(PULSE_CYC - 1);
                            r_state <= ST_PULSE;
                        end
                        HALT: begin
                            r_state <= ST_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                        WAIT_EQ: begin
                            if (w_match || w_wait_to) begin
                                r_state <= w_fin_state;
                                r_step  <= w_fin_step;
                                r_cnt   <= w_fin_cnt;
                                r_busy  <= (w_fin_state != ST_DONE);
                                r_done  <= (w_fin_state == ST_DONE);
                            end else begin
                                r_cnt <= w_cnt_inc[DELAY_W-1:0];
                            end
                        end
                        default: begin
                            if (w_op == SET_SW) r_sw <= w_arg[SW_W-1:0];
                            r_state <= w_fin_state;
                            r_step  <= w_fin_step;
                            r_cnt   <= w_fin_cnt;
                            r_busy  <= (w_fin_state != ST_DONE);
                            r_done  <= (w_fin_state == ST_DONE);
                        end
                    endcase
                end
                ST_PULSE: begin
                    if (r_pcnt == '0) begin
                        r_run   <= KEY_IDLE;
                        r_cont  <= KEY_IDLE;
                        r_state <= w_fin_state;
                        r_step  <= w_fin_step;
                        r_cnt   <= w_fin_cnt;
                        r_busy  <= (w_fin_state != ST_DONE);
                        r_done  <= (w_fin_state == ST_DONE);
                    end else begin
                        r_pcnt <= r_pcnt - PW'(1);
                    end
                end
                ST_GAP: begin
                    if (r_cnt == '0) begin
                        r_state <= w_fin_state;
                        r_step  <= w_fin_step;
                        r_busy  <= (w_fin_state != ST_DONE);
                        r_done  <= (w_fin_state == ST_DONE);
                    end else begin
                        r_cnt <= r_cnt - DELAY_W'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
            if (w_fail && r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

`ifdef STIM_ERR_LOG_EN
    logic              r_logged;
    logic [AW-1:0]     r_err_idx;
    logic [DATA_W-1:0] r_err_obs;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_logged  <= 1'b0;
            r_err_idx <= '0;
            r_err_obs <= '0;
        end else if (i_abort) begin
            r_logged <= r_logged;
        end else if (w_start_ok) begin
            r_logged  <= 1'b0;
            r_err_idx <= '0;
            r_err_obs <= '0;
        end else if (w_fail && !r_logged) begin
            r_logged  <= 1'b1;
            r_err_idx <= r_step;
            r_err_obs <= i_obs_data;
        end
    end

    assign o_err_idx = r_err_idx;
    assign o_err_obs = r_err_obs;
`else
    assign o_err_idx = '0;
    assign o_err_obs = '0;
`endif

    assign o_sw       = r_sw;
    assign o_run      = r_run;
    assign o_continue = r_cont;
    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_step_idx = r_step;
    assign o_err_cnt  = r_err_cnt;

endmodule

// File: tb/tb_lc3_stim_sequencer.sv
// Directed bench for lc3_stim_sequencer: a default instance plus an active-low-key,
// deep-script instance used for key polarity and error-count saturation.
module tb_lc3_stim_sequencer;
    import lc3_stim_pkg::*;

    logic clk, rst_n;
    int   n_cmp = 0;
    int   n_err = 0;

    logic        a_we, a_start, a_abort;
    logic [5:0]  a_addr;
    logic [30:0] a_data;
    logic [15:0] a_obs;
    logic [9:0]  a_sw;
    logic        a_run, a_cont, a_busy, a_done;
    logic [5:0]  a_step, a_eidx;
    logic [7:0]  a_ecnt;
    logic [15:0] a_eobs;

    logic        b_we, b_start, b_abort;
    logic [8:0]  b_addr;
    logic [30:0] b_data;
    logic [15:0] b_obs;
    logic [9:0]  b_sw;
    logic        b_run, b_cont, b_busy, b_done;
    logic [8:0]  b_step, b_eidx;
    logic [7:0]  b_ecnt;
    logic [15:0] b_eobs;

    lc3_stim_sequencer u_dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_prog_we(a_we), .i_prog_addr(a_addr),
        .i_prog_data(a_data), .i_start(a_start), .i_abort(a_abort), .i_obs_data(a_obs),
        .o_sw(a_sw), .o_run(a_run), .o_continue(a_cont), .o_busy(a_busy), .o_done(a_done),
        .o_step_idx(a_step), .o_err_cnt(a_ecnt), .o_err_idx(a_eidx), .o_err_obs(a_eobs)
    );

    lc3_stim_sequencer #(.DEPTH(512), .PULSE_CYC(3), .KEY_ACT_LOW(1)) u_dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_prog_we(b_we), .i_prog_addr(b_addr),
        .i_prog_data(b_data), .i_start(b_start), .i_abort(b_abort), .i_obs_data(b_obs),
        .o_sw(b_sw), .o_run(b_run), .o_continue(b_cont), .o_busy(b_busy), .o_done(b_done),
        .o_step_idx(b_step), .o_err_cnt(b_ecnt), .o_err_idx(b_eidx), .o_err_obs(b_eobs)
    );

    always #5 clk = ~clk;

    function automatic logic [30:0] ent(input stim_op_e op, input logic [15:0] arg,
                                        input logic [11:0] dly);
        return {op, arg, dly};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic prog_a(input int addr, input logic [30:0] d);
        a_we = 1'b1; a_addr = 6'(addr); a_data = d;
        tick();
        a_we = 1'b0;
    endtask

    task automatic prog_b(input int addr, input logic [30:0] d);
        b_we = 1'b1; b_addr = 9'(addr); b_data = d;
        tick();
        b_we = 1'b0;
    endtask

    task automatic start_a();
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
    endtask

    initial begin
        int cnt, cnt2;
        clk = 0; rst_n = 0;
        a_we = 0; a_start = 0; a_abort = 0; a_addr = '0; a_data = '0; a_obs = '0;
        b_we = 0; b_start = 0; b_abort = 0; b_addr = '0; b_data = '0; b_obs = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_sw",    32'(a_sw), 0);
        chk("rst_run",   32'(a_run), 0);
        chk("rst_cont",  32'(a_cont), 0);
        chk("rst_busy",  32'(a_busy), 0);
        chk("rst_done",  32'(a_done), 0);
        chk("rst_step",  32'(a_step), 0);
        chk("rst_ecnt",  32'(a_ecnt), 0);
        chk("rst_eidx",  32'(a_eidx), 0);
        chk("rst_eobs",  32'(a_eobs), 0);
        chk("rst_b_run", 32'(b_run), 1);
        chk("rst_b_cont",32'(b_cont), 1);
        rst_n = 1;
        tick();

        // SET_SW / PULSE_RUN d3 / HALT
        prog_a(0, ent(SET_SW, 16'h005A, 12'd0));
        prog_a(1, ent(PULSE_RUN, 16'h0000, 12'd3));
        prog_a(2, ent(HALT, 16'h0000, 12'd0));
        start_a();
        chk("t1_busy", 32'(a_busy), 1);
        chk("t1_step0", 32'(a_step), 0);
        cnt = 0; cnt2 = 0;
        repeat (20) begin
            tick();
            if (a_run) cnt++;
            if (a_cont) cnt2++;
        end
        chk("t1_run_cycles", 32'(cnt), 2);
        chk("t1_cont_idle", 32'(cnt2), 0);
        chk("t1_done", 32'(a_done), 1);
        chk("t1_busy_end", 32'(a_busy), 0);
        chk("t1_sw", 32'(a_sw), 32'h05A);
        chk("t1_ecnt", 32'(a_ecnt), 0);
        chk("t1_step", 32'(a_step), 2);

        // CHECKs: step 1 fails, step 2 passes, step 3 fails
        a_obs = 16'h0004;
        prog_a(0, ent(NOP, 16'h0000, 12'd0));
        prog_a(1, ent(CHECK, 16'h0003, 12'd0));
        prog_a(2, ent(CHECK, 16'h0004, 12'd0));
        prog_a(3, ent(CHECK, 16'h0005, 12'd0));
        prog_a(4, ent(HALT, 16'h0000, 12'd0));
        start_a();
        chk("t2_ecnt_clr", 32'(a_ecnt), 0);
        repeat (15) tick();
        chk("t2_done", 32'(a_done), 1);
        chk("t2_step", 32'(a_step), 4);
        chk("t2_ecnt", 32'(a_ecnt), 2);
`ifdef STIM_ERR_LOG_EN
        chk("t2_eidx", 32'(a_eidx), 1);
        chk("t2_eobs", 32'(a_eobs), 32'h0004);
`else
        chk("t2_eidx", 32'(a_eidx), 0);
        chk("t2_eobs", 32'(a_eobs), 0);
`endif

        // WAIT_EQ satisfied while still waiting
        a_obs = 16'h0000;
        prog_a(0, ent(WAIT_EQ, 16'h1234, 12'd10));
        prog_a(1, ent(HALT, 16'h0000, 12'd0));
        start_a();
        repeat (4) tick();
        chk("t3_waiting_busy", 32'(a_busy), 1);
        chk("t3_waiting_step", 32'(a_step), 0);
        a_obs = 16'h1234;
        tick();
        chk("t3_advance", 32'(a_step), 1);
        repeat (3) tick();
        chk("t3_done", 32'(a_done), 1);
        chk("t3_ecnt", 32'(a_ecnt), 0);

        // WAIT_EQ timeout after exactly 10 cycles of waiting
        a_obs = 16'h0000;
        start_a();
        repeat (10) tick();
        chk("t4_pre_ecnt", 32'(a_ecnt), 0);
        chk("t4_pre_step", 32'(a_step), 0);
        tick();
        chk("t4_to_ecnt", 32'(a_ecnt), 1);
        chk("t4_to_step", 32'(a_step), 1);
        repeat (3) tick();
        chk("t4_done", 32'(a_done), 1);

        // abort during a Run pulse, then restart from step 0
        prog_a(0, ent(SET_SW, 16'h02A5, 12'd0));
        prog_a(1, ent(CHECK, 16'h0009, 12'd0));
        prog_a(2, ent(PULSE_RUN, 16'h0000, 12'd0));
        prog_a(3, ent(HALT, 16'h0000, 12'd0));
        start_a();
        repeat (6) tick();
        chk("t5_run_on", 32'(a_run), 1);
        chk("t5_ecnt_pre", 32'(a_ecnt), 1);
        a_abort = 1'b1;
        tick();
        a_abort = 1'b0;
        chk("t5_run_off", 32'(a_run), 0);
        chk("t5_busy", 32'(a_busy), 0);
        chk("t5_done", 32'(a_done), 0);
        chk("t5_sw_kept", 32'(a_sw), 32'h2A5);
        chk("t5_ecnt_kept", 32'(a_ecnt), 1);
        repeat (3) tick();
        chk("t5_idle_busy", 32'(a_busy), 0);
        start_a();
        chk("t5_restart_step", 32'(a_step), 0);
        chk("t5_restart_ecnt", 32'(a_ecnt), 0);
        chk("t5_restart_busy", 32'(a_busy), 1);
        repeat (20) tick();
        chk("t5_rerun_done", 32'(a_done), 1);
        chk("t5_rerun_step", 32'(a_step), 3);
        chk("t5_rerun_ecnt", 32'(a_ecnt), 1);

        // 64 NOPs without HALT; a write while busy must be ignored
        for (int i = 0; i < 64; i++) prog_a(i, ent(NOP, 16'h0000, 12'd0));
        start_a();
        tick();
        prog_a(40, ent(HALT, 16'h0000, 12'd0));
        cnt = 0;
        while (!a_done && cnt < 300) begin
            tick();
            cnt++;
        end
        chk("t6_done", 32'(a_done), 1);
        chk("t6_step", 32'(a_step), 63);
        chk("t6_busy", 32'(a_busy), 0);

        // write and start in the same cycle: fetch sees the new entry
        a_we = 1'b1; a_addr = 6'd0; a_data = ent(HALT, 16'h0000, 12'd0); a_start = 1'b1;
        tick();
        a_we = 1'b0; a_start = 1'b0;
        repeat (4) tick();
        chk("t7_done", 32'(a_done), 1);
        chk("t7_step", 32'(a_step), 0);

        // active-low keys: Continue low for exactly 3 cycles, Run never moves
        prog_b(0, ent(PULSE_CONT, 16'h0000, 12'd0));
        prog_b(1, ent(HALT, 16'h0000, 12'd0));
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        cnt = 0; cnt2 = 0;
        repeat (15) begin
            tick();
            if (!b_cont) cnt++;
            if (!b_run) cnt2++;
        end
        chk("b_cont_low_cycles", 32'(cnt), 3);
        chk("b_run_low_cycles", 32'(cnt2), 0);
        chk("b_cont_idle", 32'(b_cont), 1);
        chk("b_done", 32'(b_done), 1);

        // 260 failing CHECKs: counter saturates at 255
        for (int i = 0; i < 260; i++) prog_b(i, ent(CHECK, 16'h0001, 12'd0));
        prog_b(260, ent(HALT, 16'h0000, 12'd0));
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        cnt = 0;
        while (!b_done && cnt < 1000) begin
            tick();
            cnt++;
        end
        chk("b_sat_done", 32'(b_done), 1);
        chk("b_sat_step", 32'(b_step), 260);
        chk("b_sat_ecnt", 32'(b_ecnt), 255);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
